// File: rtl/nrst_pkg.sv
// Shared types for the reset sequencer.
//   nrst_seq_state_t : sequencer phase
//     ASSERT  - master reset active or just released, outputs held low
//     HOLD    - minimum assertion window counting down, outputs held low
//     RELEASE - domains being released one by one
//     RUN     - all domains out of reset
package nrst_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } nrst_seq_state_t;

endpackage : nrst_pkg

// File: rtl/nrst_sequencer.sv
// Reset sequencer: drives DOMAINS active-low resets, one per downstream reset
// synchronizer. All outputs are held low for at least HOLD_CYCLES edges after the
// reset cause ends, then released in ascending index order, GAP_CYCLES edges apart.
// Ports:
//   CLK_I       in   clock
//   NRST_I      in   asynchronous master reset, active low (release pre-synchronized)
//   SRST_REQ_I  in   soft-reset request, level, sampled on CLK_I (ignored in ASSERT)
//   NRST_O      out  sequenced resets, active low, bit k released after bit k-1
//   BUSY_O      out  1 while any NRST_O bit is low
//   SEQ_DONE_O  out  one-cycle pulse on the edge the last domain is released
// Every output is a flop, so no decode glitches reach the synchronizers.
module nrst_sequencer
  import nrst_pkg::*;
#(
  parameter int DOMAINS     = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic               CLK_I,
  input  logic               NRST_I,
  input  logic               SRST_REQ_I,
  output logic [DOMAINS-1:0] NRST_O,
  output logic               BUSY_O,
  output logic               SEQ_DONE_O
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(DOMAINS + 1);

  // The edge that loads the counter is itself one of the counted edges' predecessor,
  // so loading N-1 gives exactly N edges until the terminal action.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  if (DOMAINS < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_params
    $error("nrst_sequencer: DOMAINS, HOLD_CYCLES and GAP_CYCLES must all be >= 1");
  end

  nrst_seq_state_t    state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;     // index of the next domain to release
  logic [DOMAINS-1:0] nrst_q, nrst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state and output logic; a soft request outside ASSERT overrides everything,
  // including the completion edge, so an aborted sequence never pulses SEQ_DONE_O.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nrst_d  = nrst_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (SRST_REQ_I && (state_q != ASSERT)) begin
      state_d = HOLD;
      cnt_d   = HOLD_LOAD;
      idx_d   = '0;
      nrst_d  = '0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ASSERT: begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          idx_d   = '0;
          nrst_d  = '0;
          busy_d  = 1'b1;
        end

        HOLD: begin
          if (cnt_q == '0) begin
            nrst_d[0] = 1'b1;
            if (DOMAINS == 1) begin
              state_d = RUN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
              cnt_d   = GAP_LOAD;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        RELEASE: begin
          if (cnt_q == '0) begin
            // OR-in only the indexed bit: released bits stay high (monotonic).
            for (int k = 0; k < DOMAINS; k++) begin
              nrst_d[k] = nrst_q[k] | (IDX_W'(k) == idx_q);
            end
            if (idx_q == IDX_W'(DOMAINS - 1)) begin
              state_d = RUN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              cnt_d = GAP_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        RUN: begin
          state_d = RUN;
        end

        default: begin
          state_d = ASSERT;
          nrst_d  = '0;
          busy_d  = 1'b1;
        end
      endcase
    end
  end

  // State, counter and output flops; master reset clears them asynchronously.
  always_ff @(posedge CLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      nrst_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      nrst_q  <= nrst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign NRST_O     = nrst_q;
  assign BUSY_O     = busy_q;
  assign SEQ_DONE_O = done_q;

endmodule : nrst_sequencer

// File: tb/tb_nrst_sequencer.sv
// Bench for nrst_sequencer: a 3-domain instance (HOLD=4, GAP=2) and a 1-domain
// instance (HOLD=1, GAP=1) share clock and master reset. The reference model
// computes outputs from the start edge s of the current sequence:
// bit k is high once edge >= s+HOLD+k*GAP, and done pulses on the last release edge.
module tb_nrst_sequencer;

  logic       clk;
  logic       nrst;
  logic       srst0, srst1;
  logic [2:0] n0;
  logic       b0, d0;
  logic [0:0] n1;
  logic       b1, d1;

  int checks = 0;
  int errors = 0;

  int ecount = 0;
  bit ina0 = 1'b1, ina1 = 1'b1;
  int s0 = 0, s1 = 0;

  nrst_sequencer #(.DOMAINS(3), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut0 (
    .CLK_I(clk), .NRST_I(nrst), .SRST_REQ_I(srst0),
    .NRST_O(n0), .BUSY_O(b0), .SEQ_DONE_O(d0)
  );

  nrst_sequencer #(.DOMAINS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .CLK_I(clk), .NRST_I(nrst), .SRST_REQ_I(srst1),
    .NRST_O(n1), .BUSY_O(b1), .SEQ_DONE_O(d1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {done, busy, nrst[2:0]} from the sequence start edge.
  function automatic logic [4:0] model(input bit ina, input int s, input int e,
                                       input int d, input int h, input int g);
    logic [2:0] n;
    logic       all;
    n   = 3'b000;
    all = 1'b1;
    if (ina) return 5'b01000;
    for (int k = 0; k < d; k++) begin
      n[k] = (e >= s + h + k * g);
      if (!n[k]) all = 1'b0;
    end
    return {(e == s + h + (d - 1) * g), ~all, n};
  endfunction

  // Model bookkeeping per clock edge.
  always @(posedge clk) begin
    ecount = ecount + 1;
    if (!nrst) begin
      ina0 = 1'b1;
      ina1 = 1'b1;
    end else begin
      if (ina0) begin ina0 = 1'b0; s0 = ecount; end
      else if (srst0) s0 = ecount;
      if (ina1) begin ina1 = 1'b0; s1 = ecount; end
      else if (srst1) s1 = ecount;
    end
  end

  always @(negedge nrst) begin
    ina0 = 1'b1;
    ina1 = 1'b1;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [4:0] e0, e1;
    e0 = model(ina0, s0, ecount, 3, 4, 2);
    e1 = model(ina1, s1, ecount, 1, 1, 1);
    checks = checks + 1;
    if ({d0, b0, n0} !== e0) begin
      errors = errors + 1;
      $display("FAIL cyc_dut0 edge %0d: got done/busy/nrst=%b expected %b", ecount, {d0, b0, n0}, e0);
    end
    checks = checks + 1;
    if ({d1, b1, n1} !== {e1[4], e1[3], e1[0]}) begin
      errors = errors + 1;
      $display("FAIL cyc_dut1 edge %0d: got done/busy/nrst=%b expected %b", ecount, {d1, b1, n1}, {e1[4], e1[3], e1[0]});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Hand-computed literal for dut0, also pinning the model.
  task automatic lit0(input string name, input logic [4:0] exp);
    logic [4:0] m;
    m = model(ina0, s0, ecount, 3, 4, 2);
    checks = checks + 1;
    if ({d0, b0, n0} !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: dut0 got %b expected %b", name, {d0, b0, n0}, exp);
    end
    checks = checks + 1;
    if (m !== exp) begin
      errors = errors + 1;
      $display("FAIL %s_model: model got %b expected %b", name, m, exp);
    end
  endtask

  task automatic lit1(input string name, input logic [2:0] exp);
    checks = checks + 1;
    if ({d1, b1, n1} !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: dut1 got %b expected %b", name, {d1, b1, n1}, exp);
    end
  endtask

  initial begin
    nrst  = 1'b0;
    srst0 = 1'b0;
    srst1 = 1'b0;
    repeat (5) step();
    lit0("rst_state", 5'b01000);
    lit1("rst_state1", 3'b010);

    // Power-on: next posedge is edge 1.
    nrst = 1'b1;
    repeat (4) step(); lit0("po_e4", 5'b01000);
    step();            lit0("po_e5", 5'b01001);
    step();            lit0("po_e6", 5'b01001);
    step();            lit0("po_e7", 5'b01011);
    step();            lit0("po_e8", 5'b01011);
    step();            lit0("po_e9", 5'b10111);
    step();            lit0("po_e10", 5'b00111);

    // Soft reset in RUN, sampled at edge t.
    srst0 = 1'b1; step(); srst0 = 1'b0;
    lit0("sr_t", 5'b01000);
    repeat (3) step(); lit0("sr_t3", 5'b01000);
    step();            lit0("sr_t4", 5'b01001);
    repeat (2) step(); lit0("sr_t6", 5'b01011);
    repeat (2) step(); lit0("sr_t8", 5'b10111);
    step();            lit0("sr_t9", 5'b00111);

    // Request during RELEASE restarts the whole sequence.
    srst0 = 1'b1; step(); srst0 = 1'b0;
    repeat (4) step(); lit0("rr_first", 5'b01001);
    srst0 = 1'b1; step(); srst0 = 1'b0;
    lit0("rr_abort", 5'b01000);
    repeat (4) step(); lit0("rr_again", 5'b01001);
    repeat (3) step(); lit0("rr_t7", 5'b01011);

    // Request on the completion edge wins: no pulse.
    srst0 = 1'b1; step(); srst0 = 1'b0;
    lit0("coinc", 5'b01000);
    repeat (4) step(); lit0("coinc_t4", 5'b01001);

    // Request held for 10 edges.
    srst0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      lit0("held_hi", 5'b01000);
    end
    srst0 = 1'b0;
    repeat (3) step(); lit0("held_t3", 5'b01000);
    step();            lit0("held_t4", 5'b01001);

    // Async master reset pulse between clock edges during RELEASE.
    step();
    #2 nrst = 1'b0;
    #1 lit0("async_clr", 5'b01000);
    lit1("async_clr1", 3'b010);
    #1 nrst = 1'b1;
    step();            lit0("ar_e1", 5'b01000);
    repeat (3) step(); lit0("ar_e4", 5'b01000);
    step();            lit0("ar_e5", 5'b01001);
    repeat (4) step(); lit0("ar_e9", 5'b10111);
    step();

    // Single-domain instance, HOLD_CYCLES=1.
    srst1 = 1'b1; step(); srst1 = 1'b0;
    lit1("d1_t", 3'b010);
    step(); lit1("d1_t1", 3'b101);
    step(); lit1("d1_t2", 3'b001);
    srst1 = 1'b1; repeat (3) step(); srst1 = 1'b0;
    lit1("d1_held", 3'b010);
    step(); lit1("d1_held_t1", 3'b101);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_nrst_sequencer
